usb_rst_seq: RTL and testbench
==============================

# usb_rst_seq

Parametrised reset-release sequencer for the usb20dev core, running in the 48 MHz domain. Holds CH_N downstream reset channels asserted for a power-on delay, then releases them one at a time with a fixed stagger: PHY/line logic first, then SIE, then packet engine and endpoints. A USB bus-reset or software request restarts the whole sequence. An optional free-running tick output serves downstream timeout logic.

## Interface
- CH_N, 3, number of reset channels, 1..16
- INIT_CYCLES, 4800, cycles all channels stay asserted after reset/request; 100 µs at 48 MHz; ≥1
- STEP_CYCLES, 48, cycles between consecutive channel releases; 1 µs; ≥1
- TICK_CYCLES, 48000, tick period; 1 ms; ≥2; used only with USB_RST_SEQ_TICK_EN
- clk  input  1  core clock, 48 MHz
- rst  input  1  reset, synchronous, active-high
- req_i  input  1  restart request, level-sensitive, active-high
- ch_rst_o  output  CH_N  per-channel reset, active-high, registered; bit 0 released first
- done_o  output  1  all channels released, registered
- tick_o  output  1  one-cycle pulse every TICK_CYCLES; present only with USB_RST_SEQ_TICK_EN

## Operation
- States:
  - INIT: all channels asserted, delay counter running.
  - STAGE: channels releasing, channel index k running.
  - RUN: all channels released.
- Reset values: state INIT, counter 0, k 0, ch_rst_o all ones, done_o 0, tick_o 0.
- INIT: counter increments each cycle. When it reaches INIT_CYCLES-1: clear ch_rst_o[0], counter to 0, k to 1.
  - If CH_N = 1: go to RUN and set done_o on that edge.
  - Otherwise go to STAGE.
- STAGE: counter increments. At STEP_CYCLES-1: clear ch_rst_o[k], counter to 0, increment k.
  - If k = CH_N-1, go to RUN and set done_o on the same edge.
- RUN: hold. Counter idle.
- Released channels stay released. ch_rst_o bits never re-assert except through rst or req_i.
- req_i high in any state: on the next edge, ch_rst_o goes to all ones, done_o to 0, counter and k to 0, state to INIT.
  - While req_i stays high, counter is held at 0.
  - Counting resumes on the first edge with req_i low.
- rst and req_i high together: identical result. rst has priority.
- Counter width: clog2(max(INIT_CYCLES, STEP_CYCLES)). Compare is exact equality, so there is no wrap.

## Timing
- Let E0 be the first rising edge sampling rst=0 and req_i=0.
- ch_rst_o[k] goes low after edge E0 + INIT_CYCLES - 1 + k*STEP_CYCLES.
- done_o goes high on the same edge as ch_rst_o[CH_N-1].
- Request latency: 1 cycle from req_i sampled high to all channels asserted.
- A request during STAGE, e.g. with channel 0 already released, re-asserts every channel within 1 cycle.
- No combinational paths from inputs to outputs.

## Configuration
- USB_RST_SEQ_TICK_EN defined:
  - tick_o port exists.
  - Tick counter is held at 0 while done_o=0.
  - First tick_o pulse occurs TICK_CYCLES edges after done_o rises, then every TICK_CYCLES.
  - A request clears the counter.
- Macro undefined: tick_o port and tick counter are absent. TICK_CYCLES is ignored.

## Structure
- Package usb_rst_seq_pkg holds:
  - State enum typedef: INIT, STAGE, RUN.
  - Default constants: CLK_HZ = 48_000_000 and the 100 µs / 1 µs / 1 ms cycle counts.
  - clog2-based width helper function.
- Sub-module usb_tick_gen: parametrised period counter with enable and synchronous clear, emitting one-cycle pulses.
  - Instantiated only under USB_RST_SEQ_TICK_EN.

## Test plan
All scenarios run at 48 MHz unless stated.
- Power-on, CH_N=3, INIT_CYCLES=10, STEP_CYCLES=4:
  - ch_rst_o = 3'b111 through edge E0+8.
  - 3'b110 after E0+9, 3'b100 after E0+13, 3'b000 after E0+17.
  - done_o rises after E0+17.
- Same configuration, 3-cycle req_i pulse asserted during STAGE with ch_rst_o=3'b110:
  - ch_rst_o = 3'b111 and done_o = 0 one cycle later.
  - Release schedule restarts from req_i falling edge with identical offsets.
- Edge cases:
  - CH_N=1, INIT_CYCLES=1: ch_rst_o low and done_o high on E0.
  - rst asserted in RUN: outputs return to reset values on the next edge.
- rst and req_i asserted simultaneously mid-STAGE, rst released first: sequence starts only after req_i also falls.
- USB_RST_SEQ_TICK_EN, TICK_CYCLES=5:
  - No tick_o before done_o.
  - tick_o pulses exactly every 5 cycles after done_o, each pulse 1 cycle wide.
  - A req_i restart suppresses ticks until done_o rises again.
- Default parameters: done_o rises 4800 + 2*48 = 4896 cycles after reset release, i.e. 102 µs ±1 cycle.

Source files
------------

// File: rtl/usb_rst_seq_pkg.sv
// Shared types, 48 MHz timing defaults and width helpers for the usb20dev reset-release sequencer.
package usb_rst_seq_pkg;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      STAGE = 2'd1,
      RUN   = 2'd2
   } state_t;

   localparam int unsigned CLK_HZ          = 32'd48_000_000;
   localparam int unsigned INIT_CYCLES_DEF = CLK_HZ / 32'd10_000;     // 100 us
   localparam int unsigned STEP_CYCLES_DEF = CLK_HZ / 32'd1_000_000;  // 1 us
   localparam int unsigned TICK_CYCLES_DEF = CLK_HZ / 32'd1_000;      // 1 ms

   // Bits needed to count 0..n-1, never less than one bit.
   function automatic int unsigned width_of(input int unsigned n);
      if (n <= 32'd2) begin
         return 32'd1;
      end else begin
         return $clog2(n);
      end
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      if (a > b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

endpackage

// File: rtl/usb_tick_gen.sv
// Period counter emitting a one-cycle pulse every PERIOD enabled cycles; clear and disable both
// return it to zero so the first pulse always lands PERIOD edges after enable rises.
module usb_tick_gen
   import usb_rst_seq_pkg::*;
#(
   parameter int unsigned PERIOD = TICK_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int unsigned    CNT_W = width_of(PERIOD);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 32'd1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_tick;

   // Period counter and registered pulse.
   always_ff @(posedge clk) begin
      if (rst || i_clr || !i_en) begin
         r_cnt  <= {CNT_W{1'b0}};
         r_tick <= 1'b0;
      end else if (r_cnt == LAST) begin
         r_cnt  <= {CNT_W{1'b0}};
         r_tick <= 1'b1;
      end else begin
         r_cnt  <= r_cnt + CNT_W'(1'b1);
         r_tick <= 1'b0;
      end
   end

   assign o_tick = r_tick;

endmodule

// File: rtl/usb_rst_seq.sv
// Reset-release sequencer: holds CH_N channels in reset, then releases them one by one (bit 0 first).
// Optional 1 ms tick output is enabled with macro USB_RST_SEQ_TICK_EN.
module usb_rst_seq
   import usb_rst_seq_pkg::*;
#(
   parameter int unsigned CH_N        = 32'd3,
   parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF,
   parameter int unsigned STEP_CYCLES = STEP_CYCLES_DEF
`ifdef USB_RST_SEQ_TICK_EN
   ,
   parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEF
`endif
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_i,
   output logic [CH_N-1:0] ch_rst_o,
   output logic            done_o
`ifdef USB_RST_SEQ_TICK_EN
   ,
   output logic            tick_o
`endif
);

   localparam int unsigned CNT_W = width_of(max_u(INIT_CYCLES, STEP_CYCLES));
   localparam int unsigned K_W   = width_of(CH_N);

   localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 32'd1);
   localparam logic [K_W-1:0]   K_LAST    = K_W'(CH_N - 32'd1);
   localparam logic [CH_N-1:0]  CH_ONE    = CH_N'(1'b1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [K_W-1:0]   r_k;
   logic [K_W-1:0]   w_k_nxt;
   logic [CH_N-1:0]  r_ch_rst;
   logic [CH_N-1:0]  w_ch_rst_nxt;
   logic             r_done;
   logic             w_done_nxt;

   // State register; reset and restart request land in the same state, holding the counter at zero.
   always_ff @(posedge clk) begin
      if (rst || req_i) begin
         r_state  <= INIT;
         r_cnt    <= {CNT_W{1'b0}};
         r_k      <= {K_W{1'b0}};
         r_ch_rst <= {CH_N{1'b1}};
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_k      <= w_k_nxt;
         r_ch_rst <= w_ch_rst_nxt;
         r_done   <= w_done_nxt;
      end
   end

   // Next-state logic: release channel 0 after the power-on delay, then one channel per step.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_k_nxt      = r_k;
      w_ch_rst_nxt = r_ch_rst;
      w_done_nxt   = r_done;
      case (r_state)
         INIT: begin
            if (r_cnt == INIT_LAST) begin
               w_ch_rst_nxt = r_ch_rst & ~CH_ONE;
               w_cnt_nxt    = {CNT_W{1'b0}};
               w_k_nxt      = K_W'(1'b1);
               if (CH_N == 32'd1) begin
                  w_state_nxt = RUN;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = STAGE;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1'b1);
            end
         end
         STAGE: begin
            if (r_cnt == STEP_LAST) begin
               w_ch_rst_nxt = r_ch_rst & ~(CH_ONE << r_k);
               w_cnt_nxt    = {CNT_W{1'b0}};
               if (r_k == K_LAST) begin
                  w_state_nxt = RUN;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_k_nxt = r_k + K_W'(1'b1);
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1'b1);
            end
         end
         RUN: begin
            w_state_nxt = RUN;
         end
         default: begin
            w_state_nxt  = INIT;
            w_cnt_nxt    = {CNT_W{1'b0}};
            w_k_nxt      = {K_W{1'b0}};
            w_ch_rst_nxt = {CH_N{1'b1}};
            w_done_nxt   = 1'b0;
         end
      endcase
   end

   assign ch_rst_o = r_ch_rst;
   assign done_o   = r_done;

`ifdef USB_RST_SEQ_TICK_EN
   usb_tick_gen #(
      .PERIOD (TICK_CYCLES)
   ) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .i_en   (r_done),
      .i_clr  (req_i),
      .o_tick (tick_o)
   );
`endif

endmodule

// File: tb/tb_usb_rst_seq.sv
// Directed bench for usb_rst_seq: small staggered config, CH_N=1 corner, default 48 MHz timing,
// and the tick output when USB_RST_SEQ_TICK_EN is defined.
module tb_usb_rst_seq;

   logic       clk = 1'b0;
   logic       a_rst = 1'b1, a_req = 1'b0;
   logic [2:0] a_ch;
   logic       a_done;
   logic       b_rst = 1'b1, b_req = 1'b0;
   logic [0:0] b_ch;
   logic       b_done;
   logic       c_rst = 1'b1, c_req = 1'b0;
   logic [2:0] c_ch;
   logic       c_done;
`ifdef USB_RST_SEQ_TICK_EN
   logic       a_tick, b_tick, c_tick;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   usb_rst_seq #(.CH_N(3), .INIT_CYCLES(10), .STEP_CYCLES(4)
`ifdef USB_RST_SEQ_TICK_EN
      , .TICK_CYCLES(5)
`endif
   ) dut_a (.clk(clk), .rst(a_rst), .req_i(a_req), .ch_rst_o(a_ch), .done_o(a_done)
`ifdef USB_RST_SEQ_TICK_EN
      , .tick_o(a_tick)
`endif
   );

   usb_rst_seq #(.CH_N(1), .INIT_CYCLES(1), .STEP_CYCLES(1)
`ifdef USB_RST_SEQ_TICK_EN
      , .TICK_CYCLES(5)
`endif
   ) dut_b (.clk(clk), .rst(b_rst), .req_i(b_req), .ch_rst_o(b_ch), .done_o(b_done)
`ifdef USB_RST_SEQ_TICK_EN
      , .tick_o(b_tick)
`endif
   );

   usb_rst_seq dut_c (.clk(clk), .rst(c_rst), .req_i(c_req), .ch_rst_o(c_ch), .done_o(c_done)
`ifdef USB_RST_SEQ_TICK_EN
      , .tick_o(c_tick)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   // Release schedule of dut_a: iteration i is checked just after edge E0+i.
   task automatic sched_a(input string tag);
      logic [2:0] exp_ch;
      for (int i = 0; i < 18; i++) begin
         edge1();
         exp_ch = (i < 9) ? 3'b111 : (i < 13) ? 3'b110 : (i < 17) ? 3'b100 : 3'b000;
         chk($sformatf("%s_ch@%0d", tag, i), {29'd0, a_ch}, {29'd0, exp_ch});
         chk($sformatf("%s_done@%0d", tag, i), {31'd0, a_done}, (i >= 17) ? 32'd1 : 32'd0);
`ifdef USB_RST_SEQ_TICK_EN
         chk($sformatf("%s_tick@%0d", tag, i), {31'd0, a_tick}, 32'd0);
`endif
      end
   endtask

   initial begin
      int         found;
      logic [2:0] prev_ch;

      repeat (3) edge1();
      chk("a_rst_ch", {29'd0, a_ch}, 32'h7);
      chk("a_rst_done", {31'd0, a_done}, 32'd0);
      chk("b_rst_ch", {31'd0, b_ch}, 32'd1);
      chk("b_rst_done", {31'd0, b_done}, 32'd0);
      chk("c_rst_ch", {29'd0, c_ch}, 32'h7);
      chk("c_rst_done", {31'd0, c_done}, 32'd0);
`ifdef USB_RST_SEQ_TICK_EN
      chk("a_rst_tick", {31'd0, a_tick}, 32'd0);
`endif

      // Power-on schedule
      a_rst = 1'b0;
      sched_a("pwr");

`ifdef USB_RST_SEQ_TICK_EN
      for (int i = 18; i < 41; i++) begin
         edge1();
         chk($sformatf("tick@%0d", i), {31'd0, a_tick},
             ((i >= 22) && ((i - 22) % 5 == 0)) ? 32'd1 : 32'd0);
      end
      a_req = 1'b1;
      edge1();
      chk("tick_req_ch", {29'd0, a_ch}, 32'h7);
      chk("tick_req_tick", {31'd0, a_tick}, 32'd0);
      a_req = 1'b0;
      sched_a("tickrst");
      for (int i = 18; i < 28; i++) begin
         edge1();
         chk($sformatf("tick2@%0d", i), {31'd0, a_tick},
             ((i >= 22) && ((i - 22) % 5 == 0)) ? 32'd1 : 32'd0);
      end
`endif

      // rst while in RUN
      a_rst = 1'b1;
      edge1();
      chk("run_rst_ch", {29'd0, a_ch}, 32'h7);
      chk("run_rst_done", {31'd0, a_done}, 32'd0);
      a_rst = 1'b0;

      // 3-cycle request during STAGE
      for (int i = 0; i < 11; i++) edge1();
      chk("stage_ch", {29'd0, a_ch}, 32'h6);
      a_req = 1'b1;
      edge1();
      chk("req_ch", {29'd0, a_ch}, 32'h7);
      chk("req_done", {31'd0, a_done}, 32'd0);
      edge1();
      edge1();
      chk("req_hold_ch", {29'd0, a_ch}, 32'h7);
      a_req = 1'b0;
      sched_a("req");

      // rst and req together mid-STAGE, rst released first
      a_rst = 1'b1;
      edge1();
      a_rst = 1'b0;
      for (int i = 0; i < 11; i++) edge1();
      chk("both_stage_ch", {29'd0, a_ch}, 32'h6);
      a_rst = 1'b1;
      a_req = 1'b1;
      edge1();
      chk("both_ch", {29'd0, a_ch}, 32'h7);
      a_rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         edge1();
         chk($sformatf("both_hold_ch@%0d", i), {29'd0, a_ch}, 32'h7);
         chk($sformatf("both_hold_done@%0d", i), {31'd0, a_done}, 32'd0);
      end
      a_req = 1'b0;
      sched_a("both");

      // CH_N=1, INIT_CYCLES=1: release on E0 itself
      b_rst = 1'b0;
      edge1();
      chk("b_e0_ch", {31'd0, b_ch}, 32'd0);
      chk("b_e0_done", {31'd0, b_done}, 32'd1);
      b_req = 1'b1;
      edge1();
      chk("b_req_ch", {31'd0, b_ch}, 32'd1);
      chk("b_req_done", {31'd0, b_done}, 32'd0);
      b_req = 1'b0;
      edge1();
      chk("b_rel_ch", {31'd0, b_ch}, 32'd0);
      chk("b_rel_done", {31'd0, b_done}, 32'd1);

      // Default timing: done after edge E0+4895
      c_rst = 1'b0;
      found = -1;
      prev_ch = 3'b111;
      for (int i = 0; i < 6000; i++) begin
         edge1();
         if (c_done) begin
            found = i;
            break;
         end
         prev_ch = c_ch;
      end
      chk("c_done_edge", found, 32'd4895);
      chk("c_final_ch", {29'd0, c_ch}, 32'h0);
      chk("c_prev_ch", {29'd0, prev_ch}, 32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
